// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: the result entry carried from each
// source to the ROB/register file, the source identifier and field widths.
package wb_pkg;

  localparam int ECAUSE_W = 5;
  localparam int ROBID_W  = 7;
  localparam int RD_W     = 6;
  localparam int RESULT_W = 32;

  typedef struct packed {
    logic                error;
    logic [ECAUSE_W-1:0] ecause;
    logic [ROBID_W-1:0]  robid;
    logic [RD_W-1:0]     rd;
    logic [RESULT_W-1:0] result;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  typedef enum logic {
    SRC_MCALU = 1'b0,
    SRC_ALU   = 1'b1
  } src_t;

endpackage

// File: rtl/wb_skid.sv
// One-entry holding buffer in front of the writeback arbiter. A load in the
// same cycle as a grant replaces the departing entry, sustaining 1 result/cycle.
module wb_skid
  import wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               grant,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic               valid,
  output logic [ENTRY_W-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end

  // Payload carries no reset; it is only meaningful while valid is set.
  always_ff @(posedge clk) begin
    if (load && !flush) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/wb_arb.sv
// Two-source writeback arbiter with per-source skid buffers and a registered
// output. Define WB_ARB_RR_EN for round-robin; default is fixed mcalu priority.
module wb_arb
  import wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mcalu_valid,
  input  logic                mcalu_error,
  input  logic [ECAUSE_W-1:0] mcalu_ecause,
  input  logic [ROBID_W-1:0]  mcalu_robid,
  input  logic [RD_W-1:0]     mcalu_rd,
  input  logic [RESULT_W-1:0] mcalu_result,
  output logic                wb_mcalu_stall,
  input  logic                alu_valid,
  input  logic                alu_error,
  input  logic [ECAUSE_W-1:0] alu_ecause,
  input  logic [ROBID_W-1:0]  alu_robid,
  input  logic [RD_W-1:0]     alu_rd,
  input  logic [RESULT_W-1:0] alu_result,
  output logic                wb_alu_stall,
  output logic                wb_valid,
  output logic                wb_error,
  output logic [ECAUSE_W-1:0] wb_ecause,
  output logic [ROBID_W-1:0]  wb_robid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [RESULT_W-1:0] wb_result,
  input  logic                rob_flush
);

  wb_entry_t m_in, a_in, m_ent, a_ent, wb_q;
  logic      m_bv, a_bv, m_load, a_load, grant_m, grant_a;

  assign m_in = {mcalu_error, mcalu_ecause, mcalu_robid, mcalu_rd, mcalu_result};
  assign a_in = {alu_error, alu_ecause, alu_robid, alu_rd, alu_result};

`ifdef WB_ARB_RR_EN
  src_t ptr;

  always_comb begin
    grant_m = 1'b0;
    grant_a = 1'b0;
    if (ptr == SRC_MCALU) begin
      grant_m = m_bv;
      grant_a = a_bv && !m_bv;
    end else begin
      grant_a = a_bv;
      grant_m = m_bv && !a_bv;
    end
  end

  // A flushed cycle's grant is discarded, so it does not rotate the pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= SRC_MCALU;
    end else if (!rob_flush) begin
      if (ptr == SRC_MCALU && grant_m) begin
        ptr <= SRC_ALU;
      end else if (ptr == SRC_ALU && grant_a) begin
        ptr <= SRC_MCALU;
      end
    end
  end
`else
  assign grant_m = m_bv;
  assign grant_a = a_bv && !m_bv;
`endif

  // Stalls depend only on buffer valids and the pointer, never on inputs.
  assign wb_mcalu_stall = m_bv && !grant_m;
  assign wb_alu_stall   = a_bv && !grant_a;
  assign m_load         = mcalu_valid && !wb_mcalu_stall;
  assign a_load         = alu_valid && !wb_alu_stall;

  wb_skid u_skid_mcalu (
    .clk   (clk),
    .rst   (rst),
    .load  (m_load),
    .grant (grant_m),
    .flush (rob_flush),
    .din   (m_in),
    .valid (m_bv),
    .dout  (m_ent)
  );

  wb_skid u_skid_alu (
    .clk   (clk),
    .rst   (rst),
    .load  (a_load),
    .grant (grant_a),
    .flush (rob_flush),
    .din   (a_in),
    .valid (a_bv),
    .dout  (a_ent)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= !rob_flush && (grant_m || grant_a);
    end
  end

  always_ff @(posedge clk) begin
    if (grant_m) begin
      wb_q <= m_ent;
    end else if (grant_a) begin
      wb_q <= a_ent;
    end
  end

  assign wb_error  = wb_q.error;
  assign wb_ecause = wb_q.ecause;
  assign wb_robid  = wb_q.robid;
  assign wb_rd     = wb_q.rd;
  assign wb_result = wb_q.result;

endmodule
